// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] XZR       = 5'd31;
  localparam int         CNT_W_DEF = 16;
  localparam int         WAIT_W    = 8;

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use hazard compare between the ID sources and the EX load destination.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       load_use
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = (ex_rd == id_rs1);
  assign w_rs2_hit = id_uses_rs2 & (ex_rd == id_rs2);
  // XZR is never a real destination, so a load into it cannot hazard.
  assign load_use  = ex_mem_read & (ex_rd != XZR) & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush/freeze controller for the 5-stage pipeline, with
// saturating stall/flush statistics and a sticky data-memory timeout flag.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int                WAIT_LIM = (MEM_TIMEOUT > 255) ? 255 : MEM_TIMEOUT;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_LIM[WAIT_W-1:0];
  localparam logic [WAIT_W-1:0] WAIT_ONE = 1;
  localparam logic [CNT_W-1:0]  CNT_ONE  = 1;

  state_e            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_load_use;
  logic              w_mem_busy;
  logic              w_freeze;
  logic              w_flush;
  logic              w_stall;
  logic [WAIT_W-1:0] w_wait_nxt;

  load_use_detect u_lud (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .load_use    (w_load_use)
  );

  assign w_mem_busy = dmem_req & ~dmem_ready;
  assign w_freeze   = (r_state == RUN) ? w_mem_busy : ~dmem_ready;
  assign w_flush    = ~w_freeze & mem_branch_taken;
  assign w_stall    = ~w_freeze & ~mem_branch_taken & w_load_use;
  assign w_wait_nxt = (r_wait == WAIT_MAX) ? r_wait : r_wait + WAIT_ONE;

  // Freeze holds every register in place, so it wins over flush and stall.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    if (reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      pipe_freeze  = 1'b1;
    end else if (w_flush) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (w_stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_mem_busy) begin
            r_state <= MEM_WAIT;
            r_wait  <= '0;
          end
        end
        MEM_WAIT: begin
          r_wait <= w_wait_nxt;
          if (w_wait_nxt == WAIT_MAX) r_timeout <= 1'b1;
          if (dmem_ready) r_state <= RUN;
        end
        default: r_state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_ONE;
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_ONE;
    end
  end

  assign mem_timeout = r_timeout;
  assign stall_count = r_stall_cnt;
  assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: stimulus pushes expected per-cycle controls and
// counters; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  localparam logic [4:0] NORM  = 5'b11000; // {pc_w, ifid_w, flush, bubble, freeze}
  localparam logic [4:0] STALL = 5'b00010;
  localparam logic [4:0] FLUSH = 5'b11110;
  localparam logic [4:0] FRZ   = 5'b00001;
  localparam logic [4:0] RST   = 5'b00110;

  typedef struct {
    logic [4:0]  ctl;
    logic [15:0] stall;
    logic [15:0] flush;
    logic        to;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_uses_rs2, ex_mem_read, mem_branch_taken, dmem_req, dmem_ready;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout;
  logic [15:0] stall_count, flush_count;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clock            (clock),
    .reset            (reset),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_uses_rs2      (id_uses_rs2),
    .ex_mem_read      (ex_mem_read),
    .ex_rd            (ex_rd),
    .mem_branch_taken (mem_branch_taken),
    .dmem_req         (dmem_req),
    .dmem_ready       (dmem_ready),
    .pc_write         (pc_write),
    .if_id_write      (if_id_write),
    .if_id_flush      (if_id_flush),
    .id_ex_bubble     (id_ex_bubble),
    .pipe_freeze      (pipe_freeze),
    .mem_timeout      (mem_timeout),
    .stall_count      (stall_count),
    .flush_count      (flush_count)
  );

  always #5 clock = ~clock;

  // Monitor: every cycle the DUT presents its controls; compare if expected.
  initial begin
    exp_t e;
    logic [4:0] act;
    forever begin
      @(negedge clock);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL %s ctl: got %b expected %b", e.name, act, e.ctl);
        end
        checks++;
        if (stall_count !== e.stall || flush_count !== e.flush) begin
          failures++;
          $display("FAIL %s counts: got stall=%0h flush=%0h expected stall=%0h flush=%0h",
                   e.name, stall_count, flush_count, e.stall, e.flush);
        end
        checks++;
        if (mem_timeout !== e.to) begin
          failures++;
          $display("FAIL %s mem_timeout: got %b expected %b", e.name, mem_timeout, e.to);
        end
      end
    end
  end

  task automatic cyc(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic uses, input logic mr, input logic [4:0] rd,
                     input logic br, input logic rq, input logic rdy,
                     input bit chk, input logic [4:0] ectl, input logic [15:0] es,
                     input logic [15:0] ef, input logic et, input string nm);
    exp_t e;
    @(posedge clock);
    #1;
    reset = rst; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = uses;
    ex_mem_read = mr; ex_rd = rd; mem_branch_taken = br;
    dmem_req = rq; dmem_ready = rdy;
    if (chk) begin
      e.ctl = ectl; e.stall = es; e.flush = ef; e.to = et; e.name = nm;
      q.push_back(e);
    end
  endtask

  initial begin
    int guard;
    reset = 1'b1; id_rs1 = '0; id_rs2 = '0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
    ex_rd = '0; mem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;

    //   rst rs1 rs2 use mr rd  br rq rdy chk ctl    stall flush to
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST,   0, 0, 0, "reset");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  0, 0, 0, "idle");
    cyc(0, 5, 0, 0, 1, 5, 0, 0, 0, 1, STALL, 0, 0, 0, "lu_rs1");
    cyc(0, 5, 0, 0, 0, 5, 0, 0, 0, 1, NORM,  1, 0, 0, "lu_rs1_after");
    cyc(0, 1, 7, 1, 1, 7, 0, 0, 0, 1, STALL, 1, 0, 0, "lu_rs2");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  2, 0, 0, "lu_rs2_after");
    cyc(0,31, 0, 0, 1,31, 0, 0, 0, 1, NORM,  2, 0, 0, "xzr");
    cyc(0, 1, 7, 0, 1, 7, 0, 0, 0, 1, NORM,  2, 0, 0, "rs2_unused");
    cyc(0, 5, 0, 0, 1, 5, 1, 0, 0, 1, FLUSH, 2, 0, 0, "flush_lu");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  2, 1, 0, "flush_after");
    // 3-cycle freeze, with a branch and load-use held inside it
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 0, "frz1");
    cyc(0, 5, 0, 0, 1, 5, 1, 1, 0, 1, FRZ,   2, 1, 0, "frz2_pend");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 0, "frz3");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, NORM,  2, 1, 0, "frz_release");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  2, 1, 0, "frz_after");
    // timeout: RUN entry cycle + 5 MEM_WAIT cycles with ready low
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 0, "to_c0");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 0, "to_c1");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 0, "to_c2");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 0, "to_c3");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 0, "to_c4");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 1, "to_c5");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, NORM,  2, 1, 1, "to_ready");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  2, 1, 1, "to_sticky");
    // reset while in MEM_WAIT must return to RUN and clear everything
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 1, "rw_c0");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, FRZ,   2, 1, 1, "rw_c1");
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 0, 1, RST,   2, 1, 1, "rw_reset");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  0, 0, 0, "rw_run");
    // stall counter saturation
    for (int i = 0; i < 65536; i++)
      cyc(0, 5, 0, 0, 1, 5, 0, 0, 0, 0, NORM, 0, 0, 0, "");
    cyc(0, 5, 0, 0, 1, 5, 0, 0, 0, 1, STALL, 16'hFFFF, 0, 0, "sat_stall");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM,  16'hFFFF, 0, 0, "sat_hold");

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clock);
      guard++;
    end
    if (q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage ARMv8 pipeline. It detects load-use hazards between ID and EX. It freezes the whole pipeline while the data memory is not ready and flushes the wrong-path instructions after a taken branch resolves in MEM. It drives the write-enable and bubble/flush controls of the PC, IF/ID and ID/EX registers and the freeze of EX/MEM and MEM/WB. It also keeps saturating stall/flush statistics and a sticky memory-timeout flag.

## Interface
- MEM_TIMEOUT, 64: maximum consecutive MEM_WAIT cycles before mem_timeout is set.
- CNT_W, 16: width of the statistics counters.

Ports:
- clock  in  1  pipeline clock. Reset reset, synchronous, active-high; clock clock.
- reset  in  1  synchronous, active-high.
- id_rs1  in  5  first source register of the instruction in ID.
- id_rs2  in  5  second source register of the instruction in ID.
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, STUR, CBZ).
- ex_mem_read  in  1  MemRead of the instruction in EX (ID/EX output).
- ex_rd  in  5  write register of the instruction in EX.
- mem_branch_taken  in  1  branch in MEM resolved taken (PCSrc).
- dmem_req  in  1  MEM-stage instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID loads a NOP.
- id_ex_bubble  out  1  ID/EX loads all-zero control (bubble).
- pipe_freeze  out  1  EX/MEM and MEM/WB hold; overrides all other controls.
- mem_timeout  out  1  sticky error, set when MEM_WAIT exceeds MEM_TIMEOUT.
- stall_count  out  CNT_W  load-use stall cycles, saturating.
- flush_count  out  CNT_W  taken-branch flush events, saturating.

## Operation
- FSM states: RUN, MEM_WAIT.
- Control outputs are Mealy: they are combinational from state and inputs, so they act in the same cycle.
- load_use = ex_mem_read & ex_rd != 31 & (ex_rd == id_rs1 | (id_uses_rs2 & ex_rd == id_rs2)). XZR (31) never creates a hazard.
- mem_busy = dmem_req & !dmem_ready.
- Priority when events coincide: freeze > flush > load-use.
- Freeze is active when (RUN & mem_busy) or (MEM_WAIT & !dmem_ready). It drives pipe_freeze=1, pc_write=0 and if_id_write=0, with if_id_flush=0 and id_ex_bubble=0 (hold, not bubble). A pending flush or stall is re-evaluated once freeze ends, because inputs are held by the frozen registers.
- Flush (not frozen, mem_branch_taken=1) drives if_id_flush=1, id_ex_bubble=1, pc_write=1 (the branch target loads) and if_id_write=1. Any load-use is ignored, since its instruction is squashed.
- Load-use (not frozen, no flush) drives pc_write=0, if_id_write=0 and id_ex_bubble=1.
- With no event: pc_write=1, if_id_write=1, all others 0.
- Transitions:
  - RUN -> MEM_WAIT on mem_busy.
  - MEM_WAIT -> RUN on dmem_ready.
  - MEM_WAIT holds otherwise.
- Wait counter: cleared on entry to MEM_WAIT, incremented each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, mem_timeout sets and stays set until reset. The FSM keeps waiting.
- stall_count increments once per load-use cycle. flush_count increments once per flush cycle. Both saturate at all-ones.

## Timing
- While reset=1: state RUN, wait counter 0, stall_count 0, flush_count 0, mem_timeout 0. Outputs during reset: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, pipe_freeze=0.
- Control latency is 0 cycles (combinational). State, counters and flags update on the rising clock edge.
- A load-use produces exactly one bubble cycle. On the next edge the load moves to MEM, so the hazard clears through the inputs.
- Reset asserted during MEM_WAIT returns to RUN on the next edge. The wait counter and mem_timeout clear.
- Counter width: MEM_TIMEOUT must fit in an 8-bit wait counter; the counter saturates at MEM_TIMEOUT.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT);
  - localparam XZR = 5'd31;
  - the default CNT_W.
- One combinational sub-module, load_use_detect (inputs id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd; output load_use), reused later by the forwarding unit.

## Test plan
- LDUR X5 in EX, ADD reading X5 as rs1 in ID -> one cycle of pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1; the next cycle is normal.
- ex_rd=31 with ex_mem_read=1 and id_rs1=31 -> no stall. Also id_rs2 matches but id_uses_rs2=0 -> no stall.
- dmem_req=1 with dmem_ready low for 3 cycles -> pipe_freeze=1 for 3 cycles, state MEM_WAIT; ready=1 releases on the 4th cycle, with pipe_freeze=0 in that cycle.
- mem_branch_taken=1 together with load_use=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_count +1, stall_count unchanged.
- MEM_TIMEOUT=4, dmem_ready held low for 6 cycles -> mem_timeout rises after the 4th wait cycle and stays at 1 after ready. Reset clears it.
- Force stall_count to all-ones via 65536 load-use cycles, then one more -> stays at 0xFFFF.
